// File: rtl/i8253_pkg.sv
// Shared encodings and helpers for the 8253 bus initiator.
package i8253_pkg;

  typedef enum logic {OP_WRITE = 1'b0, OP_LATCH_READ = 1'b1} op_e;

  localparam logic [1:0] ADDR_CNT0 = 2'b00;
  localparam logic [1:0] ADDR_CNT1 = 2'b01;
  localparam logic [1:0] ADDR_CNT2 = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  localparam logic [1:0] RW_LATCH = 2'b00;
  localparam logic [1:0] RW_LSB   = 2'b01;
  localparam logic [1:0] RW_MSB   = 2'b10;
  localparam logic [1:0] RW_BOTH  = 2'b11;

  typedef enum logic [1:0] {H_IDLE, H_XFER, H_GAP, H_DONE} host_state_e;
  typedef enum logic [1:0] {P_IDLE, P_SETUP, P_STROBE, P_HOLD} phase_e;

  function automatic logic [7:0] build_cw(input logic [1:0] sel, input logic [1:0] rw,
                                          input logic [2:0] mode, input logic bcd);
    return {sel, rw, mode, bcd};
  endfunction

  // Index of the last bus cycle: control word is cycle 0, data bytes follow.
  function automatic logic [1:0] last_index(input logic [1:0] rw);
    return (rw == RW_BOTH) ? 2'd2 : ((rw == RW_LATCH) ? 2'd0 : 2'd1);
  endfunction

endpackage

// File: rtl/i8253_bus_cycle.sv
// One SETUP/STROBE/HOLD transfer on the 8253 pins; all pins registered.
// done is high in the last HOLD cycle; rdata is captured at the end of the last STROBE cycle.
module i8253_bus_cycle
  import i8253_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       is_read,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a1,
  output logic       a0,
  output logic [7:0] dout,
  output logic       oe,
  input  logic [7:0] din
);
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  phase_e     phase_q;
  logic [3:0] cnt_q;
  logic       read_q, cs_q, rd_q, wr_q, oe_q;
  logic [1:0] addr_q;
  logic [7:0] dout_q, rdata_q;

  assign done  = (phase_q == P_HOLD) && (cnt_q == 4'd0);
  assign rdata = rdata_q;
  assign cs_n  = cs_q;
  assign rd_n  = rd_q;
  assign wr_n  = wr_q;
  assign {a1, a0} = addr_q;
  assign dout  = dout_q;
  assign oe    = oe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= P_IDLE;
      cnt_q   <= 4'd0;
      read_q  <= 1'b0;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      oe_q    <= 1'b0;
      addr_q  <= 2'b00;
      dout_q  <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      case (phase_q)
        P_IDLE: if (start) begin
          phase_q <= P_SETUP;
          cnt_q   <= SETUP_LD;
          read_q  <= is_read;
          cs_q    <= 1'b0;
          addr_q  <= addr;
          dout_q  <= is_read ? 8'h00 : wdata;
          oe_q    <= !is_read;
        end
        P_SETUP: if (cnt_q == 4'd0) begin
          phase_q <= P_STROBE;
          cnt_q   <= STROBE_LD;
          rd_q    <= !read_q;
          wr_q    <= read_q;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        P_STROBE: if (cnt_q == 4'd0) begin
          phase_q <= P_HOLD;
          cnt_q   <= HOLD_LD;
          rd_q    <= 1'b1;
          wr_q    <= 1'b1;
          if (read_q) rdata_q <= din;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        P_HOLD: if (cnt_q == 4'd0) begin
          phase_q <= P_IDLE;
          cs_q    <= 1'b1;
          oe_q    <= 1'b0;
          addr_q  <= 2'b00;
          dout_q  <= 8'h00;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        default: phase_q <= P_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/i8253_host.sv
// Bus initiator for the 8253: one request becomes a control-word write plus 0-2 data transfers.
// The first bus cycle starts from the acceptance edge; later ones start from a one-cycle GAP.
module i8253_host
  import i8253_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [1:0]  req_sel,
  input  logic [1:0]  req_rw,
  input  logic [2:0]  req_mode,
  input  logic        req_bcd,
  input  logic [15:0] req_count,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        CS,
  output logic        RD,
  output logic        WR,
  output logic        A1,
  output logic        A0,
  output logic [7:0]  bus_dout,
  output logic        bus_oe,
  input  logic [7:0]  bus_din
);
  host_state_e state_q;
  op_e         op_q;
  logic [1:0]  sel_q, rw_q, idx_q, last_q;
  logic [15:0] count_q, rsp_data_q;
  logic [7:0]  lo_q, hi_q, lo_d, hi_d;
  logic        rsp_valid_q, rsp_err_q;

  logic       legal, cur_hi, bc_start, bc_read, bc_done;
  logic [1:0] bc_addr;
  logic [7:0] bc_wdata, bc_rdata;

  assign req_ready = (state_q == H_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign legal     = (req_sel != ADDR_CTRL) && (req_mode <= 3'd5);
  // idx_q names the byte being started (GAP) or in flight (XFER).
  assign cur_hi    = (rw_q == RW_MSB) || ((rw_q == RW_BOTH) && (idx_q == 2'd2));

  always_comb begin
    bc_start = 1'b0;
    bc_read  = 1'b0;
    bc_addr  = ADDR_CTRL;
    bc_wdata = build_cw(req_sel, (op_e'(req_op) == OP_LATCH_READ) ? RW_LATCH : req_rw,
                        req_mode, req_bcd);
    lo_d     = lo_q;
    hi_d     = hi_q;
    if (state_q == H_IDLE) begin
      bc_start = req_valid && legal;
    end else if (state_q == H_GAP) begin
      bc_start = 1'b1;
      bc_read  = (op_q == OP_LATCH_READ);
      bc_addr  = sel_q;
      bc_wdata = cur_hi ? count_q[15:8] : count_q[7:0];
    end
    if ((state_q == H_XFER) && bc_done && (op_q == OP_LATCH_READ) && (idx_q != 2'd0)) begin
      if (cur_hi) hi_d = bc_rdata;
      else        lo_d = bc_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= H_IDLE;
      op_q        <= OP_WRITE;
      sel_q       <= 2'b00;
      rw_q        <= 2'b00;
      idx_q       <= 2'd0;
      last_q      <= 2'd0;
      count_q     <= 16'h0000;
      lo_q        <= 8'h00;
      hi_q        <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 16'h0000;
    end else begin
      case (state_q)
        H_IDLE: if (req_valid) begin
          op_q    <= op_e'(req_op);
          sel_q   <= req_sel;
          rw_q    <= req_rw;
          count_q <= req_count;
          idx_q   <= 2'd0;
          last_q  <= last_index(req_rw);
          lo_q    <= 8'h00;
          hi_q    <= 8'h00;
          if (legal) begin
            state_q <= H_XFER;
          end else begin
            state_q     <= H_DONE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end
        end
        H_XFER: if (bc_done) begin
          lo_q <= lo_d;
          hi_q <= hi_d;
          if (idx_q == last_q) begin
            state_q     <= H_DONE;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= (op_q == OP_LATCH_READ) ? {hi_d, lo_d} : 16'h0000;
          end else begin
            idx_q   <= idx_q + 2'd1;
            state_q <= H_GAP;
          end
        end
        H_GAP: state_q <= H_XFER;
        H_DONE: begin
          state_q     <= H_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= 16'h0000;
        end
        default: state_q <= H_IDLE;
      endcase
    end
  end

  i8253_bus_cycle #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_bus (
    .clk    (clk),
    .reset  (reset),
    .start  (bc_start),
    .is_read(bc_read),
    .addr   (bc_addr),
    .wdata  (bc_wdata),
    .done   (bc_done),
    .rdata  (bc_rdata),
    .cs_n   (CS),
    .rd_n   (RD),
    .wr_n   (WR),
    .a1     (A1),
    .a0     (A0),
    .dout   (bus_dout),
    .oe     (bus_oe),
    .din    (bus_din)
  );

endmodule

// File: tb/tb_i8253_host.sv
// Bench for i8253_host: default-timing instance driven by directed and random requests,
// plus a SETUP=3/STROBE=1/HOLD=2 instance fed back-to-back requests.
module tb_i8253_host;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default-timing instance
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_op = 1'b0, req_bcd = 1'b0;
  logic [1:0]  req_sel = 2'd0, req_rw = 2'd0;
  logic [2:0]  req_mode = 3'd0;
  logic [15:0] req_count = 16'h0;
  logic        req_ready, rsp_valid, rsp_err, CS, RD, WR, A1, A0, bus_oe;
  logic [15:0] rsp_data;
  logic [7:0]  bus_dout, bus_din;

  i8253_host u_dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_sel(req_sel), .req_rw(req_rw), .req_mode(req_mode), .req_bcd(req_bcd),
    .req_count(req_count), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .CS(CS), .RD(RD), .WR(WR), .A1(A1), .A0(A0), .bus_dout(bus_dout), .bus_oe(bus_oe),
    .bus_din(bus_din)
  );

  // peripheral model: bytes served in read order
  logic [7:0] per_mem [0:3];
  int rd_cnt = 0, rd_base = 0;
  assign bus_din = per_mem[2'(rd_cnt - rd_base)];

  // pin monitor for the default instance
  logic [9:0] wlog[$];
  int  cs_cnt = 0, viol = 0, wr_run = 0;
  logic wr_prev = 1'b1, rd_prev = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      wr_prev <= 1'b1;
      rd_prev <= 1'b1;
      wr_run  <= 0;
    end else begin
      wr_prev <= WR;
      rd_prev <= RD;
      if (!CS) cs_cnt <= cs_cnt + 1;
      if (!WR) begin
        wr_run <= wr_run + 1;
        if (CS || !bus_oe) viol <= viol + 1;
      end else if (!wr_prev) begin
        wlog.push_back({A1, A0, bus_dout});
        wr_run <= 0;
        if (wr_run != 2) viol <= viol + 1;
      end
      if (!RD && (CS || bus_oe)) viol <= viol + 1;
      if (RD && !rd_prev) rd_cnt <= rd_cnt + 1;
    end
  end

  // alternate-timing instance
  logic        rst_b = 1'b0, req_valid_b = 1'b0;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, cs_b, rd_b, wr_b, a1_b, a0_b, oe_b;
  logic [15:0] rsp_data_b;
  logic [7:0]  dout_b;
  logic [7:0]  din_b = 8'h00;

  i8253_host #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) u_dut6 (
    .clk(clk), .reset(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_op(1'b0),
    .req_sel(2'd0), .req_rw(2'b01), .req_mode(3'd3), .req_bcd(1'b0), .req_count(16'h4321),
    .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
    .CS(cs_b), .RD(rd_b), .WR(wr_b), .A1(a1_b), .A0(a0_b), .bus_dout(dout_b), .bus_oe(oe_b),
    .bus_din(din_b)
  );

  int wr_runs_b[$], cs_gaps_b[$], acc_b[$], rsp_b[$];
  int wr_run_b = 0, cs_hi_b = 0;
  logic cs_started_b = 1'b0;
  always @(negedge clk) begin
    if (!rst_b) begin
      if (!wr_b) wr_run_b <= wr_run_b + 1;
      else if (wr_run_b != 0) begin
        wr_runs_b.push_back(wr_run_b);
        wr_run_b <= 0;
      end
      if (cs_b) cs_hi_b <= cs_hi_b + 1;
      else if (cs_hi_b != 0) begin
        if (cs_started_b) cs_gaps_b.push_back(cs_hi_b);
        cs_started_b <= 1'b1;
        cs_hi_b <= 0;
      end
      if (req_valid_b && req_ready_b) acc_b.push_back(cyc);
      if (rsp_valid_b) rsp_b.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one request and compare against a rule-level model of the whole transaction.
  task automatic run_req(input string tag, input logic op, input logic [1:0] sel,
                         input logic [1:0] rw, input logic [2:0] mode, input logic bcd,
                         input logic [15:0] cnt, input logic [7:0] lo, input logic [7:0] hi);
    logic        legal;
    logic [9:0]  exp_w[$];
    logic [15:0] exp_data;
    int nbytes, ncyc, exp_lat, exp_reads, lat, w_base, c_base;
    legal    = (sel != 2'd3) && (mode <= 3'd5);
    nbytes   = (rw == 2'd0) ? 0 : ((rw == 2'd3) ? 2 : 1);
    ncyc     = 1 + nbytes;
    exp_lat  = legal ? ncyc * (1 + 2 + 1) + (ncyc - 1) + 1 : 1;
    exp_reads = (legal && op) ? nbytes : 0;
    exp_data = (legal && op) ? {rw[1] ? hi : 8'h00, rw[0] ? lo : 8'h00} : 16'h0000;
    if (legal) begin
      exp_w.push_back({2'b11, sel, op ? 2'b00 : rw, mode, bcd});
      if (!op && rw[0]) exp_w.push_back({sel, cnt[7:0]});
      if (!op && rw[1]) exp_w.push_back({sel, cnt[15:8]});
    end
    per_mem[0] = (rw == 2'd2) ? hi : lo;
    per_mem[1] = hi;
    @(negedge clk);
    check({tag, ".ready"}, req_ready, 1'b1);
    rd_base = rd_cnt;
    w_base  = wlog.size();
    c_base  = cs_cnt;
    req_op = op; req_sel = sel; req_rw = rw; req_mode = mode; req_bcd = bcd; req_count = cnt;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_count = 16'($urandom);
    req_sel   = 2'($urandom);
    lat = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".err"}, rsp_err, !legal);
    check({tag, ".data"}, rsp_data, exp_data);
    @(negedge clk);
    check({tag, ".pulse"}, rsp_valid, 1'b0);
    #1;
    check({tag, ".nwrites"}, wlog.size() - w_base, exp_w.size());
    for (int i = 0; i < exp_w.size() && w_base + i < wlog.size(); i++)
      check({tag, ".wbyte"}, wlog[w_base + i], exp_w[i]);
    check({tag, ".nreads"}, rd_cnt - rd_base, exp_reads);
    if (!legal) check({tag, ".nocs"}, cs_cnt - c_base, 0);
  endtask

  initial begin
    int falls, c_base, seen;
    logic wr_last;
    #3 rst = 1'b1; rst_b = 1'b1;
    #1;
    check("rst.CS", CS, 1'b1);
    check("rst.RD", RD, 1'b1);
    check("rst.WR", WR, 1'b1);
    check("rst.A", {A1, A0}, 2'b00);
    check("rst.dout", bus_dout, 8'h00);
    check("rst.oe", bus_oe, 1'b0);
    check("rst.ready", req_ready, 1'b1);
    check("rst.rsp", {rsp_valid, rsp_err, rsp_data}, 18'h0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    run_req("t1", 1'b0, 2'd1, 2'b11, 3'd2, 1'b0, 16'h1234, 8'h00, 8'h00);
    run_req("t2", 1'b1, 2'd0, 2'b11, 3'd0, 1'b0, 16'h0000, 8'hCD, 8'hAB);
    run_req("t3a", 1'b0, 2'd2, 2'b01, 3'd0, 1'b0, 16'h00FF, 8'h00, 8'h00);
    run_req("t3b", 1'b0, 2'd2, 2'b10, 3'd0, 1'b0, 16'h0500, 8'h00, 8'h00);
    run_req("t4sel", 1'b0, 2'd3, 2'b11, 3'd1, 1'b0, 16'h5555, 8'h00, 8'h00);
    run_req("t4mode", 1'b1, 2'd0, 2'b11, 3'd6, 1'b1, 16'h5555, 8'h11, 8'h22);
    run_req("latch0", 1'b1, 2'd2, 2'b00, 3'd4, 1'b1, 16'h0000, 8'h77, 8'h88);
    for (int r = 0; r < 24; r++)
      run_req("rnd", 1'($urandom), 2'($urandom), 2'($urandom), 3'($urandom), 1'($urandom),
              16'($urandom), 8'($urandom), 8'($urandom));
    check("pin_rules", viol, 0);

    // reset during the STROBE of the second byte
    @(negedge clk);
    req_op = 1'b0; req_sel = 2'd1; req_rw = 2'b11; req_mode = 3'd3; req_count = 16'hBEEF;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    falls = 0;
    wr_last = 1'b1;
    for (int k = 0; k < 60 && falls < 2; k++) begin
      @(negedge clk);
      if (!WR && wr_last) falls++;
      wr_last = WR;
    end
    check("t5.reached", falls, 2);
    #2 rst = 1'b1;
    #1;
    check("t5.WR", WR, 1'b1);
    check("t5.CS", CS, 1'b1);
    check("t5.oe", bus_oe, 1'b0);
    check("t5.ready", req_ready, 1'b1);
    check("t5.rsp", rsp_valid, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    c_base = cs_cnt;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("t5.norsp", seen, 0);
    check("t5.idle_cs", cs_cnt - c_base, 0);

    // alternate timing, back-to-back requests
    @(negedge clk);
    #2 rst_b = 1'b0;
    @(posedge clk);
    #1 req_valid_b = 1'b1;
    seen = 0;
    for (int k = 0; k < 100 && seen < 2; k++) begin
      @(negedge clk);
      if (rsp_valid_b) seen++;
    end
    #1 req_valid_b = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("t6.nrsp", rsp_b.size(), 2);
    check("t6.nacc", acc_b.size(), 2);
    if (acc_b.size() >= 2 && rsp_b.size() >= 2) begin
      check("t6.latency", rsp_b[0] - acc_b[0], 2 * (3 + 1 + 2) + 1 + 1);
      check("t6.backtoback", acc_b[1] - rsp_b[0], 1);
    end
    check("t6.nstrobe", wr_runs_b.size(), 4);
    foreach (wr_runs_b[i]) check("t6.wr_width", wr_runs_b[i], 1);
    check("t6.ngaps", cs_gaps_b.size(), 3);
    if (cs_gaps_b.size() == 3) begin
      check("t6.gap0", cs_gaps_b[0], 1);
      check("t6.gap1", cs_gaps_b[1], 2);
      check("t6.gap2", cs_gaps_b[2], 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
